// File: rtl/zuc_pkg.sv
// zuc_pkg: shared widths, scheduler state encoding and the round-robin
// pointer helper used by the zuc request scheduler.
package zuc_pkg;

    localparam int ZUC_KEY_W  = 128;
    localparam int ZUC_IV_W   = 128;
    localparam int ZUC_WORD_W = 32;
    localparam int ZUC_ID_W   = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_KICK  = 3'd2,
        S_RUN   = 3'd3,
        S_CLOSE = 3'd4
    } zuc_state_e;

    // Index following id, wrapping modulo n.
    function automatic logic [ZUC_ID_W-1:0] rr_next(input logic [ZUC_ID_W-1:0] id,
                                                    input int unsigned         n);
        return (32'(id) >= n - 1) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/zuc_rr_arb.sv
// zuc_rr_arb: combinational round-robin pick. Returns the first requester
// at or after ptr (wrapping modulo N_REQ) as a one-hot grant plus its index.
module zuc_rr_arb
    import zuc_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [ZUC_ID_W-1:0] ptr,
    output logic [N_REQ-1:0]    grant,
    output logic [ZUC_ID_W-1:0] idx,
    output logic                any
);

    logic [7:0] req8;
    logic [3:0] pos;

    // Scan N_REQ positions starting at ptr and keep the first one requesting
    always_comb begin
        req8 = 8'(req);
        idx  = '0;
        any  = 1'b0;
        pos  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, ptr} + 4'(i);
            if (pos >= 4'(N_REQ)) pos = pos - 4'(N_REQ);
            if (!any && req8[pos[2:0]]) begin
                any = 1'b1;
                idx = pos[2:0];
            end
        end
    end

    assign grant = any ? N_REQ'(8'd1 << idx) : '0;

endmodule

// File: rtl/zuc_req_sched.sv
// zuc_req_sched: shares one zuc keystream core among N_REQ requesters.
// A granted job's key/IV/length are latched, the core is restarted through
// core_rst_n, each core word is forwarded to the owner and the job closes
// after the last word. Optional watchdog: define ZUC_SCHED_TIMEOUT_EN.
//
// Request handshake: a requester holds req[i] with stable key/iv/len until
// it sees the one-cycle ack[i] pulse; the job is owned by the scheduler from
// that point, and dropping req afterwards never cancels it. Responses have
// no backpressure: rsp_valid qualifies rsp_id/rsp_data/rsp_last for one cycle.
module zuc_req_sched
    import zuc_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*ZUC_KEY_W-1:0]   req_key,
    input  logic [N_REQ*ZUC_IV_W-1:0]    req_iv,
    input  logic [N_REQ*LEN_W-1:0]       req_len,
    output logic [N_REQ-1:0]             ack,
    output logic                         rsp_valid,
    output logic [ZUC_ID_W-1:0]          rsp_id,
    output logic [ZUC_WORD_W-1:0]        rsp_data,
    output logic                         rsp_last,
    output logic                         rsp_err,
    output logic                         busy,
    output logic                         core_rst_n,
    output logic [ZUC_KEY_W-1:0]         core_k,
    output logic [ZUC_IV_W-1:0]          core_iv,
    output logic [LEN_W-1:0]             core_L,
    input  logic                         core_done,
    input  logic [ZUC_WORD_W-1:0]        core_Z
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("zuc_req_sched: parameter out of range");
    end

    zuc_state_e            state_q, state_d;
    logic [ZUC_ID_W-1:0]   rr_ptr_q;
    logic [ZUC_ID_W-1:0]   id_q;
    logic [LEN_W:0]        cnt_q;
    logic [LEN_W:0]        cnt_next;
    logic [N_REQ-1:0]      gnt;
    logic [ZUC_ID_W-1:0]   gnt_idx;
    logic                  gnt_any;
    logic [LEN_W-1:0]      sel_len;
    logic                  take;
    logic                  job_ok;
    logic                  run_word;
    logic                  last_word;
    logic                  tmo;

    zuc_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign sel_len  = req_len[gnt_idx*LEN_W +: LEN_W];
    // While ack is high the owner has not yet dropped req, so no grant that cycle.
    assign take     = (state_q == S_IDLE) && gnt_any && (ack == '0);
    assign job_ok   = take && (sel_len != '0);
    assign run_word = (state_q == S_RUN) && core_done;
    assign cnt_next = cnt_q + 1'b1;
    assign last_word = run_word && (cnt_next == {1'b0, core_L});

`ifdef ZUC_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdog_q;

    assign tmo = (state_q == S_RUN) && !core_done && (wdog_q == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog: cycles spent in S_RUN since the last core word
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 wdog_q <= '0;
        else if (state_q != S_RUN || core_done)  wdog_q <= '0;
        else                                     wdog_q <= wdog_q + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (job_ok) state_d = S_LOAD;
            S_LOAD:  state_d = S_KICK;
            S_KICK:  state_d = S_RUN;
            S_RUN:   if (last_word || tmo) state_d = S_CLOSE;
            S_CLOSE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: core released only while a job is actually running
    always_comb begin
        core_rst_n = (state_q == S_KICK) || (state_q == S_RUN);
        busy       = (state_q != S_IDLE);
    end

    // Job latch, word counter, response pulses and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            core_k    <= '0;
            core_iv   <= '0;
            core_L    <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            rr_ptr_q  <= '0;
        end else begin
            ack       <= '0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= tmo;
            if (take) begin
                ack     <= gnt;
                core_k  <= req_key[gnt_idx*ZUC_KEY_W +: ZUC_KEY_W];
                core_iv <= req_iv[gnt_idx*ZUC_IV_W +: ZUC_IV_W];
                core_L  <= sel_len;
                id_q    <= gnt_idx;
                if (sel_len == '0) rr_ptr_q <= rr_next(gnt_idx, N_REQ);
            end
            if (state_q == S_KICK) cnt_q <= '0;
            if (run_word) begin
                rsp_valid <= 1'b1;
                rsp_data  <= core_Z;
                rsp_id    <= id_q;
                rsp_last  <= last_word;
                cnt_q     <= cnt_next;
            end
            if (tmo) rsp_id <= id_q;
            if (state_q == S_CLOSE) rr_ptr_q <= rr_next(id_q, N_REQ);
        end
    end

endmodule

// File: tb/tb_zuc_req_sched.sv
// tb_zuc_req_sched: randomized requesters, a keystream core stub and a
// scoreboard predicting grant order and every response word.
// Build with ZUC_SCHED_TIMEOUT_EN to include the watchdog scenario.
module tb_zuc_req_sched;

    localparam int N_REQ       = 4;
    localparam int LEN_W       = 8;
    localparam int TIMEOUT_CYC = 64;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*128-1:0]    req_key;
    logic [N_REQ*128-1:0]    req_iv;
    logic [N_REQ*LEN_W-1:0]  req_len;
    logic [N_REQ-1:0]        ack;
    logic                    rsp_valid;
    logic [2:0]              rsp_id;
    logic [31:0]             rsp_data;
    logic                    rsp_last;
    logic                    rsp_err;
    logic                    busy;
    logic                    core_rst_n;
    logic [127:0]            core_k;
    logic [127:0]            core_iv;
    logic [LEN_W-1:0]        core_L;
    logic                    core_done;
    logic [31:0]             core_Z;

    zuc_req_sched #(.N_REQ(N_REQ), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_key    (req_key),
        .req_iv     (req_iv),
        .req_len    (req_len),
        .ack        (ack),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .core_rst_n (core_rst_n),
        .core_k     (core_k),
        .core_iv    (core_iv),
        .core_L     (core_L),
        .core_done  (core_done),
        .core_Z     (core_Z)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d required < 100000", cyc);
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    endtask

    // Keystream produced by the core stub: GM/T 0001 vector 1 for key=iv=0,
    // otherwise an arbitrary mix of key, IV and word index.
    function automatic logic [31:0] ks_word(input logic [127:0] k, input logic [127:0] iv,
                                            input int w);
        if (k == '0 && iv == '0 && w == 0) return 32'h27bede74;
        if (k == '0 && iv == '0 && w == 1) return 32'h018082da;
        return k[31:0] ^ k[95:64] ^ {iv[15:0], iv[127:112]} ^ (32'(w) * 32'h9e3779b9) ^ 32'h0f0f1234;
    endfunction

    // ---------------- core stub ----------------
    bit stall_mode = 1'b0;

    task automatic run_core();
        logic [127:0] k;
        logic [127:0] iv;
        int           len;
        bit           alive;
        k     = core_k;
        iv    = core_iv;
        len   = int'(core_L);
        alive = 1'b1;
        for (int c = 0; c < int'($urandom_range(90, 110)) && alive; c++) begin
            @(posedge clk); #1;
            if (!core_rst_n) alive = 1'b0;
        end
        for (int w = 0; w < len && alive; w++) begin
            if (stall_mode && w >= 1) begin
                while (alive) begin
                    @(posedge clk); #1;
                    if (!core_rst_n) alive = 1'b0;
                end
            end else begin
                core_done = 1'b1;
                core_Z    = ks_word(k, iv, w);
                @(posedge clk); #1;
                core_done = 1'b0;
                core_Z    = $urandom;
                if (!core_rst_n) alive = 1'b0;
                for (int g = 0; g < 2 && alive; g++) begin
                    @(posedge clk); #1;
                    if (!core_rst_n) alive = 1'b0;
                end
            end
        end
        while (alive) begin
            @(posedge clk); #1;
            if (!core_rst_n) alive = 1'b0;
        end
    endtask

    initial begin
        core_done = 1'b0;
        core_Z    = '0;
        forever begin
            @(posedge clk); #1;
            if (core_rst_n) run_core();
        end
    end

    // ---------------- requesters and reference model ----------------
    int            want[N_REQ];
    int            len_cfg[N_REQ];
    int            jlen[N_REQ];
    int            n_ack[N_REQ];
    int            ack_lat[N_REQ];
    int            raise_cyc[N_REQ];
    bit            zk[N_REQ];
    logic [127:0]  cur_key[N_REQ];
    logic [127:0]  cur_iv[N_REQ];

    logic [35:0]   exp_q[$];     // {id[2:0], last, data[31:0]}
    int            grant_log[$];
    logic [31:0]   word_log[$];
    int            ptr_m = 0;
    int            n_words = 0;
    int            n_err = 0;
    int            last_valid_cyc = 0;
    int            err_gap = 0;
    bit            err_allowed = 1'b0;
    bit            saw_core_on = 1'b0;

    task automatic monitor();
        int          idx;
        int          exp_id;
        logic [35:0] e;
        if (rst) return;
        if (core_rst_n) saw_core_on = 1'b1;
        if (ack != '0) begin
            check("ack_onehot", 64'($countones(ack)), 64'd1);
            idx = -1;
            for (int i = N_REQ - 1; i >= 0; i--) if (ack[i]) idx = i;
            exp_id = -1;
            for (int off = N_REQ - 1; off >= 0; off--)
                if (req[(ptr_m + off) % N_REQ]) exp_id = (ptr_m + off) % N_REQ;
            check("grant_id", 64'(idx), 64'(exp_id));
            check("ack_req_held", 64'(req[idx]), 64'd1);
            for (int w = 0; w < jlen[idx]; w++)
                exp_q.push_back({3'(idx), (w == jlen[idx] - 1), ks_word(cur_key[idx], cur_iv[idx], w)});
            ptr_m = (idx + 1) % N_REQ;
            n_ack[idx]++;
            ack_lat[idx] = cyc - raise_cyc[idx];
            grant_log.push_back(idx);
            req[idx] = 1'b0;
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e[35:33]));
                check("rsp_data", 64'(rsp_data), 64'(e[31:0]));
                check("rsp_last", 64'(rsp_last), 64'(e[32]));
            end
            n_words++;
            last_valid_cyc = cyc;
            word_log.push_back(rsp_data);
        end
        if (rsp_err) begin
            n_err++;
            err_gap = cyc - last_valid_cyc;
            check("rsp_err_allowed", 64'(err_allowed), 64'd1);
            check("err_no_last", 64'(rsp_last), 64'd0);
            if (exp_q.size() == 0) begin
                check("err_unexpected", 64'(rsp_err), 64'd0);
            end else begin
                e = exp_q[0];
                check("err_id", 64'(rsp_id), 64'(e[35:33]));
                while (exp_q.size() > 0 && exp_q[0][35:33] == e[35:33]) void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N_REQ; i++) begin
            if (!req[i] && want[i] > 0) begin
                jlen[i]    = (len_cfg[i] >= 0) ? len_cfg[i] : int'($urandom_range(0, 5));
                cur_key[i] = zk[i] ? '0 : {$urandom, $urandom, $urandom, $urandom};
                cur_iv[i]  = zk[i] ? '0 : {$urandom, $urandom, $urandom, $urandom};
                req_key[128*i +: 128]    = cur_key[i];
                req_iv[128*i +: 128]     = cur_iv[i];
                req_len[LEN_W*i +: LEN_W] = LEN_W'(jlen[i]);
                req[i]       = 1'b1;
                raise_cyc[i] = cyc;
                want[i]--;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        drive();
    endtask

    task automatic run_until_idle(input string tag, input int max_cyc);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            step();
            n++;
            done = (req == '0) && (exp_q.size() == 0) && !busy && (ack == '0);
            for (int i = 0; i < N_REQ; i++) if (want[i] != 0) done = 1'b0;
        end
        check({tag, "_drain"}, 64'(done), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},        64'(ack), 64'd0);
        check({tag, "_rsp_valid"},  64'(rsp_valid), 64'd0);
        check({tag, "_rsp_id"},     64'(rsp_id), 64'd0);
        check({tag, "_rsp_data"},   64'(rsp_data), 64'd0);
        check({tag, "_rsp_last"},   64'(rsp_last), 64'd0);
        check({tag, "_rsp_err"},    64'(rsp_err), 64'd0);
        check({tag, "_busy"},       64'(busy), 64'd0);
        check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd0);
        check({tag, "_core_k"},     core_k[63:0] | core_k[127:64], 64'd0);
        check({tag, "_core_iv"},    core_iv[63:0] | core_iv[127:64], 64'd0);
        check({tag, "_core_L"},     64'(core_L), 64'd0);
    endtask

    task automatic clear_requesters();
        req = '0;
        for (int i = 0; i < N_REQ; i++) begin
            want[i] = 0;
            len_cfg[i] = -1;
            zk[i] = 1'b0;
            n_ack[i] = 0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_requesters();
        exp_q.delete();
        ptr_m = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    int words0;
    int guard;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst     = 1'b1;
        req_key = '0;
        req_iv  = '0;
        req_len = '0;
        clear_requesters();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;
        step();
        check_reset_outputs("rst_rel");

        // Test vector job on requester 0
        len_cfg[0] = 2; zk[0] = 1'b1; want[0] = 1;
        word_log.delete();
        run_until_idle("t1", 1000);
        check("t1_words", 64'(word_log.size()), 64'd2);
        if (word_log.size() >= 2) begin
            check("t1_z1", 64'(word_log[0]), 64'h27bede74);
            check("t1_z2", 64'(word_log[1]), 64'h018082da);
        end
        check("t1_ack_cnt", 64'(n_ack[0]), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_core_parked", 64'(core_rst_n), 64'd0);
        zk[0] = 1'b0;

        // Two simultaneous requesters
        len_cfg[1] = 3; len_cfg[2] = 3; want[1] = 1; want[2] = 1;
        grant_log.delete();
        run_until_idle("t2", 2000);
        check("t2_grants", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() >= 2) begin
            check("t2_first", 64'(grant_log[0]), 64'd1);
            check("t2_second", 64'(grant_log[1]), 64'd2);
        end
        check("t2_ack1", 64'(n_ack[1]), 64'd1);
        check("t2_ack2", 64'(n_ack[2]), 64'd1);

        // Zero-length job
        saw_core_on = 1'b0;
        words0 = n_words;
        len_cfg[3] = 0; want[3] = 1;
        run_until_idle("t3", 100);
        check("t3_ack_lat", 64'(ack_lat[3]), 64'd1);
        check("t3_ack_cnt", 64'(n_ack[3]), 64'd1);
        check("t3_core_off", 64'(saw_core_on), 64'd0);
        check("t3_no_words", 64'(n_words - words0), 64'd0);

        // Everyone requesting from reset
        apply_reset();
        for (int i = 0; i < N_REQ; i++) begin
            len_cfg[i] = 1;
            want[i] = (i == 0) ? 2 : 1;
        end
        grant_log.delete();
        run_until_idle("t4", 3000);
        check("t4_grants", 64'(grant_log.size()), 64'd5);
        for (int j = 0; j < 5; j++)
            if (j < grant_log.size()) check("t4_order", 64'(grant_log[j]), 64'(exp_order[j]));

        // Reset in the middle of a job
        clear_requesters();
        len_cfg[2] = 10; want[2] = 1;
        words0 = n_words;
        guard = 0;
        while ((n_words - words0) < 5 && guard < 2000) begin
            step();
            guard++;
        end
        check("t5_reach_word5", 64'(n_words - words0), 64'd5);
        rst = 1'b1;
        clear_requesters();
        #1;
        check_reset_outputs("t5_async");
        step();
        check_reset_outputs("t5_held");
        step();
        @(negedge clk);
        exp_q.delete();
        ptr_m = 0;
        rst = 1'b0;
        words0 = n_words;
        len_cfg[1] = 1; want[1] = 1;
        run_until_idle("t5_after", 1000);
        check("t5_after_words", 64'(n_words - words0), 64'd1);

`ifdef ZUC_SCHED_TIMEOUT_EN
        // Core stalls after its first word
        clear_requesters();
        err_allowed = 1'b1;
        stall_mode  = 1'b1;
        n_err = 0;
        len_cfg[0] = 4; len_cfg[1] = 1; want[0] = 1; want[1] = 1;
        grant_log.delete();
        run_until_idle("t6", 3000);
        check("t6_err_cnt", 64'(n_err), 64'd1);
        check("t6_err_gap", 64'(err_gap), 64'(TIMEOUT_CYC));
        check("t6_grants", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() >= 2) begin
            check("t6_first", 64'(grant_log[0]), 64'd0);
            check("t6_next", 64'(grant_log[1]), 64'd1);
        end
        stall_mode  = 1'b0;
        err_allowed = 1'b0;
`endif

        // Randomized rounds
        for (int r = 0; r < 4; r++) begin
            clear_requesters();
            for (int i = 0; i < N_REQ; i++) want[i] = int'($urandom_range(0, 2));
            run_until_idle("rand", 6000);
        end

        // Maximum length must not wrap the word counter
        clear_requesters();
        words0 = n_words;
        len_cfg[3] = 255; want[3] = 1;
        run_until_idle("maxlen", 3000);
        check("maxlen_words", 64'(n_words - words0), 64'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
